// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock generator.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_t;

  localparam int SPI_DEFAULT_W = 8;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter and sclk register for the SPI master.
// Emits one-cycle rise_en/fall_en strobes on the cycle before sclk toggles.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic toggle_en,
  output logic sclk,
  output logic rise_en,
  output logic fall_en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  // tick marks the last cycle of a half period; with toggle_en low the
  // counter still times the interval but sclk is left alone.
  assign tick    = en && (cnt_q == '0);
  assign rise_en = tick && toggle_en && !sclk_q;
  assign fall_en = tick && toggle_en && sclk_q;
  assign sclk    = sclk_q;

  always_comb begin
    // NOTE: every signal gets its default first so no path can infer a latch.
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr) begin
      cnt_d  = RELOAD;
      sclk_d = 1'b0;
    end else if (en) begin
      if (tick) begin
        cnt_d = RELOAD;
        if (toggle_en) sclk_d = !sclk_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-transfer SPI master, mode 0 (CPOL=0, CPHA=0).
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order; default is MSB first.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = SPI_DEFAULT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              clk_en, clk_clr, clk_toggle;
  logic              rise_en, fall_en, tick;
  logic              first_bit, next_bit;
  logic [DATA_W-1:0] tx_shift, rx_shift;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (clk_en),
    .clr      (clk_clr),
    .toggle_en(clk_toggle),
    .sclk     (sclk),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .tick     (tick)
  );

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign first_bit = data_in[0];
  assign tx_shift  = {1'b0, tx_q[DATA_W-1:1]};
  assign next_bit  = tx_shift[0];
  assign rx_shift  = {miso, rx_q[DATA_W-1:1]};
`else
  assign first_bit = data_in[DATA_W-1];
  assign tx_shift  = {tx_q[DATA_W-2:0], 1'b0};
  assign next_bit  = tx_shift[DATA_W-1];
  assign rx_shift  = {rx_q[DATA_W-2:0], miso};
`endif

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    bit_cnt_d  = bit_cnt_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clk_en     = 1'b0;
    clk_clr    = 1'b0;
    clk_toggle = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_clr = 1'b1;
        cs_d    = 1'b1;
        busy_d  = 1'b0;
        if (start) begin
          tx_d      = data_in;
          rx_d      = '0;
          bit_cnt_d = '0;
          mosi_d    = first_bit;
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end

      // The strobe that ends SETUP is the first rising sclk edge.
      SETUP: begin
        clk_en     = 1'b1;
        clk_toggle = 1'b1;
        if (rise_en) begin
          rx_d    = rx_shift;
          state_d = XFER;
        end
      end

      XFER: begin
        clk_en     = 1'b1;
        clk_toggle = 1'b1;
        if (rise_en) rx_d = rx_shift;
        if (fall_en) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            mosi_d  = 1'b0;
            state_d = HOLD;
          end else begin
            tx_d   = tx_shift;
            mosi_d = next_bit;
          end
        end
      end

      // The counter keeps timing here, but sclk stays parked low.
      HOLD: begin
        clk_en = 1'b1;
        if (tick) begin
          cs_d       = 1'b1;
          data_out_d = rx_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      bit_cnt_q  <= '0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      bit_cnt_q  <= bit_cnt_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign cs       = cs_q;
  assign mosi     = mosi_q;

endmodule

// File: doc/spi_master.md
# spi_master

Single-byte SPI master (mode 0: CPOL=0, CPHA=0) that is the initiating end of the team's existing `spi_slave`. A host pulses `start` with a byte. The block asserts `cs`, generates `sclk` from the system clock, and shifts the byte out on `mosi` while capturing `miso`. It sits between the host logic and the off-chip or on-chip SPI slave, and reports completion with a one-cycle `done` pulse.

## Interface
- `CLK_DIV`, default 2: `sclk` half-period in `clk` cycles; legal range is 1 or more.
- `DATA_W`, default 8: bits per transfer.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request a transfer; sampled only in IDLE.
- `data_in` input, `DATA_W` bits: byte to transmit; latched on the accepted `start`.
- `busy` output, 1 bit: a transfer is in progress.
- `done` output, 1 bit: one-cycle pulse when a transfer completes.
- `data_out` output, `DATA_W` bits: received byte; updated when `done` asserts and held until the next `done`.
- `cs` output, 1 bit: chip select, active-low.
- `sclk` output, 1 bit: serial clock; idles low.
- `mosi` output, 1 bit: serial data out.
- `miso` input, 1 bit: serial data in.

## Operation
- All outputs are registered.
- Reset values: `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `data_out`=0. Internal state goes to IDLE, the counters to 0 and the shift registers to 0.
- IDLE state:
  - `cs`=1 and `busy`=0.
  - When `start`=1: latch `data_in` into the tx shift register, drive `mosi` with the first bit (the MSB), drop `cs`, set `busy`, and go to SETUP.
- SETUP state: hold `sclk`=0 for `CLK_DIV` cycles, then raise `sclk` and go to XFER.
- XFER state: toggle `sclk` every `CLK_DIV` cycles.
  - On each rising edge, sample `miso` into the rx shift register, shifting in at the LSB.
  - On each falling edge, advance the tx shift register and present the next bit on `mosi`.
  - After the `DATA_W`-th falling edge, drive `mosi`=0 and go to HOLD.
- HOLD state: keep `cs`=0 for `CLK_DIV` cycles. Then raise `cs`, copy rx into `data_out`, pulse `done`, clear `busy`, and return to IDLE.
- `start` is ignored whenever `busy`=1. No queueing is provided.
- `start` in the same cycle as `done` is accepted, because the state is already IDLE. This gives back-to-back transfers with a one-cycle `cs` high gap.
- `data_in` is not sampled after acceptance, so changing it mid-transfer has no effect.
- Reset mid-transfer: all outputs return to their reset values immediately (`cs` goes high asynchronously), and no `done` is issued.

## Timing
- `start` accepted at cycle T gives `cs`=0 and `busy`=1 at T+1.
- Edge k (k = 0 to 2·`DATA_W`−1) occurs at T+1+`CLK_DIV`·(1+k). Even k are rising edges and odd k are falling edges.
- `done`=1, `cs`=1 and `busy`=0 all occur at T+1+`CLK_DIV`·(2·`DATA_W`+1).
- With the defaults (`CLK_DIV`=2, `DATA_W`=8), `done` occurs at T+35.
- `mosi` changes only on falling edges of `sclk` or at `cs` assertion, so it is stable for `CLK_DIV` cycles around each rising edge.
- The half-period counter width is `$clog2(CLK_DIV+1)`. It reloads at every edge and at each state entry.
- The bit counter width is `$clog2(DATA_W+1)` and counts falling edges.

## Configuration
- Macro: `SPI_MASTER_LSB_FIRST_EN`.
- When defined:
  - The tx bit order is LSB first: the first `mosi` bit is `data_in[0]` and the register shifts right.
  - The rx register shifts in at the MSB, so `data_out` is presented in natural bit order.
- When undefined: the order is MSB first, as described above, which matches `spi_slave`.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_state_t` with values IDLE, SETUP, XFER, HOLD;
  - constant `SPI_DEFAULT_W` = 8.
- One sub-module, `spi_clk_gen`:
  - holds the `CLK_DIV` counter and the `sclk` register;
  - takes `en` and `clr` inputs;
  - outputs single-cycle `rise_en` and `fall_en` strobes.
- The top module contains the FSM, the shift registers and the bit counter.

## Test plan
- Basic transfer: `CLK_DIV`=2, `data_in`=8'd189 (1011_1101), and a slave model that returns 8'h5A on `miso`.
  - `mosi` must read 1,0,1,1,1,1,0,1 at successive `sclk` rises.
  - `data_out` must be 8'h5A, with `done` at T+35.
  - Exactly 8 `sclk` pulses must occur.
- Loopback:
  - Tie `miso`=`mosi` and transfer 8'hC3; `data_out` must be 8'hC3.
  - Repeat with 8'h00 and 8'hFF.
- Busy and back-to-back:
  - Pulse `start` with 8'h11 at T+10 while busy; it must be ignored, with `data_out` and the `mosi` pattern unchanged.
  - Assert `start` in the `done` cycle; a second transfer must begin, with `cs` high for exactly 1 cycle.
- Reset mid-transfer:
  - Assert `rst` at T+12; `cs`=1, `sclk`=0 and `data_out`=0 must appear with no clock edge, and no `done` may follow.
  - A subsequent transfer must complete normally.
- Fastest divider:
  - `CLK_DIV`=1 with 8'hA5 in loopback; the `sclk` period must be 2 cycles, `done` must occur at T+18 and `data_out` must be 8'hA5.
- LSB-first build:
  - With `SPI_MASTER_LSB_FIRST_EN` defined, transfer 8'hBD; `mosi` must read 1,0,1,1,1,1,0,1.
  - In loopback, `data_out` must be 8'hBD.
